// File: rtl/modport_apb_slave_if.sv
// modport_apb_slave_if: APB3 bus bundle for a single completer on PSEL1.
// The requester drives select/controls/data; the completer answers.
interface modport_apb_slave_if;
    logic        PSEL1;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL1,
        output PENABLE,
        output PWRITE,
        output PADDR,
        output PWDATA,
        input  PRDATA,
        input  PREADY,
        input  PSLVERR
    );

    modport slave (
        input  PSEL1,
        input  PENABLE,
        input  PWRITE,
        input  PADDR,
        input  PWDATA,
        output PRDATA,
        output PREADY,
        output PSLVERR
    );
endinterface

// File: rtl/modport_apb_slave.sv
// modport_apb_slave: APB3 completer with a word-addressed register file.
// Define APB_WAIT_STATES_EN to insert WAIT_CYCLES wait states per transfer.
module modport_apb_slave #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               PRESET,
    modport_apb_slave_if.slave bus
);
    localparam int          AW    = $clog2(DEPTH);
    localparam logic [31:0] LIMIT = 32'(4 * DEPTH);
`ifdef APB_WAIT_STATES_EN
    localparam logic [3:0]  WAITS = 4'(WAIT_CYCLES);
`else
    localparam logic [3:0]  WAITS = 4'd0;
`endif

    if (DEPTH < 2 || DEPTH > 1024 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of 2 in 2..1024");
    end
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("WAIT_CYCLES must be in 0..15");
    end

    typedef enum logic {
        IDLE,
        ACCESS
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] paddr_q;
    logic        pwrite_q;
    logic [31:0] pwdata_q;
    logic [31:0] prdata_q;
    logic        pready_q;
    logic        pslverr_q;
    logic [31:0] mem_q [DEPTH];

    logic          setup;
    logic [31:0]   lk_addr;
    logic          lk_wr;
    logic          lk_err;
    logic [AW-1:0] lk_idx;
    logic [31:0]   lk_data;
    logic          q_err;
    logic [AW-1:0] q_idx;

    // Response lookup uses the live bus when a transfer starts, else the capture.
    always_comb begin
        setup   = bus.PSEL1 && !bus.PENABLE;
        lk_addr = setup ? bus.PADDR : paddr_q;
        lk_wr   = setup ? bus.PWRITE : pwrite_q;
        lk_err  = (lk_addr[1:0] != 2'b00) || (lk_addr >= LIMIT);
        lk_idx  = lk_addr[AW+1:2];
        lk_data = (lk_wr || lk_err) ? 32'd0 : mem_q[lk_idx];
        q_err   = (paddr_q[1:0] != 2'b00) || (paddr_q >= LIMIT);
        q_idx   = paddr_q[AW+1:2];
    end

    always_ff @(posedge clk or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            if (state_q == ACCESS && !bus.PSEL1) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else if (setup) begin
                // New setup phase, also restarts an ACCESS left without PENABLE
                state_q  <= ACCESS;
                cnt_q    <= WAITS;
                paddr_q  <= bus.PADDR;
                pwrite_q <= bus.PWRITE;
                pwdata_q <= bus.PWDATA;
                if (WAITS == 4'd0) begin
                    pready_q  <= 1'b1;
                    pslverr_q <= lk_err;
                    prdata_q  <= lk_data;
                end
            end else if (state_q == ACCESS) begin
                if (pready_q) begin
                    if (pwrite_q && !q_err) begin
                        mem_q[q_idx] <= pwdata_q;
                    end
                    state_q <= IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        pready_q  <= 1'b1;
                        pslverr_q <= lk_err;
                        prdata_q  <= lk_data;
                    end
                end
            end
        end
    end

    assign bus.PRDATA  = prdata_q;
    assign bus.PREADY  = pready_q;
    assign bus.PSLVERR = pslverr_q;
endmodule

// File: tb/tb_modport_apb_slave.sv
// tb_modport_apb_slave: randomized APB transfers against an array model
// of the register file, plus directed reset, error, back-to-back and abort cases.
module tb_modport_apb_slave;
    localparam int DEPTH = 64;
    localparam int WAIT  = 2;
`ifdef APB_WAIT_STATES_EN
    localparam int EXP_W = WAIT;
`else
    localparam int EXP_W = 0;
`endif

    logic clk = 1'b0;
    logic PRESET;
    always #5 clk = ~clk;

    modport_apb_slave_if bus ();

    modport_apb_slave #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .clk    (clk),
        .PRESET (PRESET),
        .bus    (bus)
    );

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] mem_m [DEPTH];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic bit bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
    endfunction

    // Starts at posedge+1; ends at posedge+1 after the completion edge.
    task automatic xfer(input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input bit hold);
        int          w;
        bit          e;
        logic [31:0] exp_rd;
        logic [31:0] idx;
        w      = 0;
        e      = bad(a);
        idx    = a >> 2;
        exp_rd = (wr || e) ? 32'd0 : mem_m[idx[5:0]];
        bus.PSEL1   = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = wr;
        bus.PADDR   = a;
        bus.PWDATA  = d;
        chk("setup_rdy", 32'(bus.PREADY), 32'd0);
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        while (!bus.PREADY && w <= 20) begin
            chk("wait_data", bus.PRDATA, 32'd0);
            chk("wait_err", 32'(bus.PSLVERR), 32'd0);
            w++;
            @(posedge clk); #1;
        end
        chk("waits", 32'(w), 32'(EXP_W));
        chk(wr ? "wr_slverr" : "rd_slverr", 32'(bus.PSLVERR), 32'(e));
        if (!wr) chk("rdata", bus.PRDATA, exp_rd);
        @(posedge clk); #1;
        if (wr && !e) mem_m[idx[5:0]] = d;
        bus.PENABLE = 1'b0;
        if (!hold) bus.PSEL1 = 1'b0;
        chk("done_rdy", 32'(bus.PREADY), 32'd0);
        chk("done_err", 32'(bus.PSLVERR), 32'd0);
        chk("done_data", bus.PRDATA, 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bit          wr;
        bit          hold;
        int          kind;
        logic [31:0] a;
        bus.PSEL1   = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = '0;
        bus.PWDATA  = '0;
        PRESET      = 1'b1;
        foreach (mem_m[i]) mem_m[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", 32'(bus.PREADY), 32'd0);
        chk("rst_err", 32'(bus.PSLVERR), 32'd0);
        chk("rst_data", bus.PRDATA, 32'd0);
        PRESET = 1'b0;
        idle(1);

        xfer(1'b1, 32'h04, 32'hA5A5A5A5, 1'b0);
        idle(1);
        xfer(1'b0, 32'h04, 32'h0, 1'b0);

        xfer(1'b1, 32'h00, 32'hCAFE0000, 1'b0);
        xfer(1'b1, 32'h102, 32'h12345678, 1'b0);
        xfer(1'b1, 32'h100, 32'h12345678, 1'b0);
        xfer(1'b0, 32'h100, 32'h0, 1'b0);
        xfer(1'b0, 32'h00, 32'h0, 1'b0);

        xfer(1'b1, 32'h00, 32'h1, 1'b1);
        xfer(1'b0, 32'h00, 32'h0, 1'b0);

        // Abort: PSEL1 drops during ACCESS of a write
        xfer(1'b1, 32'h20, 32'h11111111, 1'b0);
        bus.PSEL1   = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b1;
        bus.PADDR   = 32'h20;
        bus.PWDATA  = 32'hBADC0FFE;
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        if (EXP_W > 0) begin
            @(posedge clk); #1;
            chk("abort_wait_rdy", 32'(bus.PREADY), 32'd0);
        end
        bus.PSEL1 = 1'b0;
        @(posedge clk); #1;
        bus.PENABLE = 1'b0;
        chk("abort_rdy", 32'(bus.PREADY), 32'd0);
        idle(3);
        chk("abort_idle_rdy", 32'(bus.PREADY), 32'd0);
        xfer(1'b0, 32'h20, 32'h0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            wr   = 1'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 9));
            if (kind < 7)
                a = 32'($urandom_range(0, DEPTH - 1)) << 2;
            else if (kind == 7)
                a = (32'($urandom_range(0, DEPTH - 1)) << 2) |
                    32'($urandom_range(1, 3));
            else if (kind == 8)
                a = 32'(4 * DEPTH) + (32'($urandom_range(0, 1000)) << 2);
            else
                a = $urandom | 32'h8000_0000;
            hold = ($urandom_range(0, 3) == 0) && (i != 299);
            xfer(wr, a, $urandom, hold);
            if (!hold) idle(int'($urandom_range(0, 2)));
        end

        // Reset in the middle of a write
        xfer(1'b1, 32'h10, 32'h12121212, 1'b0);
        bus.PSEL1   = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b1;
        bus.PADDR   = 32'h10;
        bus.PWDATA  = 32'hDEADBEEF;
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        #2;
        PRESET = 1'b1;
        #1;
        chk("mid_rst_rdy", 32'(bus.PREADY), 32'd0);
        chk("mid_rst_err", 32'(bus.PSLVERR), 32'd0);
        chk("mid_rst_data", bus.PRDATA, 32'd0);
        bus.PSEL1   = 1'b0;
        bus.PENABLE = 1'b0;
        foreach (mem_m[i]) mem_m[i] = '0;
        @(posedge clk); #1;
        PRESET = 1'b0;
        idle(1);
        xfer(1'b0, 32'h10, 32'h0, 1'b0);
        xfer(1'b0, 32'h04, 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
